// File: rtl/sd_sector_responder.sv
// Sector responder for the sd_lba/sd_rd/sd_wr/sd_ack protocol, backed by a dual-port byte store.
// Optional write protect input enabled by defining SD_WRPROT_EN.
module sd_sector_responder #(
  parameter int SECTORS   = 64,
  parameter int ACK_DELAY = 4
) (
  input  logic                              clk_sys,
  input  logic                              RESET_n,
  input  logic [31:0]                       sd_lba,
  input  logic                              sd_rd,
  input  logic                              sd_wr,
  output logic                              sd_ack,
  output logic [8:0]                        sd_buff_addr,
  output logic [7:0]                        sd_buff_dout,
  output logic                              sd_buff_wr,
  input  logic [7:0]                        sd_buff_din,
  output logic                              busy,
  output logic                              err,
`ifdef SD_WRPROT_EN
  input  logic                              wp,
`endif
  input  logic [$clog2(SECTORS*512)-1:0]    st_addr,
  input  logic [7:0]                        st_din,
  input  logic                              st_we,
  output logic [7:0]                        st_dout
);

  localparam int DEPTH = SECTORS * 512;
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = AW - 9;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_GAP} state_t;

  logic [7:0]    mem [DEPTH];
  state_t        state_q, state_d;
  logic [7:0]    dly_q, dly_d;
  logic [9:0]    xcnt_q, xcnt_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          rd_q, rd_d;
  logic          err_q, err_d;
  logic          bwr_q, bwr_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    st_dout_q;
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic          wp_i;

`ifdef SD_WRPROT_EN
  assign wp_i = wp;
`else
  assign wp_i = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    xcnt_d  = xcnt_q;
    sec_d   = sec_q;
    rd_d    = rd_q;
    err_d   = err_q;
    bwr_d   = 1'b0;
    dout_d  = dout_q;
    mem_we  = 1'b0;
    mem_idx = {sec_q, xcnt_q[9:1]};
    case (state_q)
      S_IDLE: begin
        if (sd_rd | sd_wr) begin
          sec_d  = sd_lba[SW-1:0];
          rd_d   = sd_rd;
          // A protected write still runs the full handshake; err flags it and blocks the commit.
          err_d  = (sd_lba >= 32'(SECTORS)) | (!sd_rd & wp_i);
          xcnt_d = 10'd0;
          if (ACK_DELAY == 0) begin
            state_d = S_XFER;
          end else begin
            dly_d   = 8'(ACK_DELAY - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dly_q == 8'd0) state_d = S_XFER;
        else               dly_d   = dly_q - 8'd1;
      end
      S_XFER: begin
        xcnt_d = xcnt_q + 10'd1;
        // Even cycle fetches the byte, odd cycle presents it (read) or commits din (write).
        if (rd_q) begin
          if (!xcnt_q[0]) begin
            bwr_d  = 1'b1;
            dout_d = err_q ? 8'hFF : mem[mem_idx];
          end
        end else if (xcnt_q[0] && !err_q) begin
          mem_we = 1'b1;
        end
        if (xcnt_q == 10'd1023) state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= S_IDLE;
      dly_q   <= 8'd0;
      xcnt_q  <= 10'd0;
      sec_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      bwr_q   <= 1'b0;
      dout_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      xcnt_q  <= xcnt_d;
      sec_q   <= sec_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      bwr_q   <= bwr_d;
      dout_q  <= dout_d;
    end
  end

  // Store is never reset; the sector-side write is ordered last so it wins an address collision.
  always_ff @(posedge clk_sys) begin
    if (st_we)  mem[st_addr] <= st_din;
    if (mem_we) mem[mem_idx] <= sd_buff_din;
    st_dout_q <= mem[st_addr];
  end

  assign sd_ack       = (state_q == S_XFER);
  assign busy         = (state_q != S_IDLE);
  assign sd_buff_addr = xcnt_q[9:1];
  assign sd_buff_wr   = bwr_q;
  assign sd_buff_dout = dout_q;
  assign err          = err_q;
  assign st_dout      = st_dout_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Bench for sd_sector_responder: scoreboarded sector reads, writes, back-to-back save loop and reset abort.
module tb_sd_sector_responder;
  localparam int SECTORS   = 64;
  localparam int ACK_DELAY = 4;
  localparam int AW        = $clog2(SECTORS * 512);

  logic          clk_sys = 1'b0;
  logic          RESET_n = 1'b0;
  logic [31:0]   sd_lba = '0;
  logic          sd_rd = 1'b0, sd_wr = 1'b0;
  logic          sd_ack, sd_buff_wr, busy, err;
  logic [8:0]    sd_buff_addr;
  logic [7:0]    sd_buff_dout;
  logic [7:0]    sd_buff_din = '0;
  logic          wp = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [7:0]    st_din = '0;
  logic          st_we = 1'b0;
  logic [7:0]    st_dout;

  int total = 0;
  int bad   = 0;
  logic [7:0] model [SECTORS*512];
  logic [7:0] exp_q [$];

  sd_sector_responder #(.SECTORS(SECTORS), .ACK_DELAY(ACK_DELAY)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .busy(busy), .err(err),
`ifdef SD_WRPROT_EN
    .wp(wp),
`endif
    .st_addr(st_addr), .st_din(st_din), .st_we(st_we), .st_dout(st_dout)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int sel, input logic [31:0] lba, input logic [8:0] k);
    int v;
    case (sel)
      0:       v = int'(~k[7:0]);
      1:       v = (int'(lba) * 37) + (int'(k) * 13) + (int'(k) >> 3);
      default: v = int'(k[7:0]) ^ 32'h5A;
    endcase
    return v[7:0];
  endfunction

  task automatic pb_write(input int a, input logic [7:0] d);
    st_addr = AW'(a); st_din = d; st_we = 1'b1;
    model[a] = d;
    @(negedge clk_sys);
    st_we = 1'b0;
  endtask

  task automatic pb_chk(input int a);
    st_addr = AW'(a); st_we = 1'b0;
    @(negedge clk_sys);
    chk($sformatf("pb[%0d]", a), st_dout, model[a]);
  endtask

  // Runs one sector transfer from IDLE; returns on the following IDLE negedge (or mid-cycle after an abort).
  task automatic do_xfer(input logic [31:0] lba, input logic rd, input logic wr, input int sel,
                         input int abort_at);
    int n, c;
    bit aborted, in_rng;
    in_rng  = (lba < 32'(SECTORS));
    aborted = 0;
    exp_q.delete();
    if (rd)
      for (int k = 0; k < 512; k++)
        exp_q.push_back(in_rng ? model[int'(lba[5:0]) * 512 + k] : 8'hFF);
    sd_lba = lba; sd_rd = rd; sd_wr = wr;
    n = 0;
    do begin @(negedge clk_sys); n++; end while (!sd_ack && n < 50);
    chk("ack_latency", n, ACK_DELAY + 1);
    sd_rd = 1'b0; sd_wr = 1'b0;
    c = 0;
    while (sd_ack && c < 1100) begin
      sd_buff_din = pat(sel, lba, sd_buff_addr);
      chk("buff_addr", {23'd0, sd_buff_addr}, c >> 1);
      if (abort_at >= 0 && c == 2 * abort_at) begin
        #2 RESET_n = 1'b0;
        #1;
        chk("abort_ack", sd_ack, 0);
        chk("abort_busy", busy, 0);
        chk("abort_bwr", sd_buff_wr, 0);
        if (wr && !rd && in_rng && !wp)
          for (int k = 0; k < abort_at; k++) model[int'(lba[5:0]) * 512 + k] = pat(sel, lba, 9'(k));
        aborted = 1;
        break;
      end
      chk("strobe", sd_buff_wr, (rd && (c % 2 == 1)));
      if (sd_buff_wr) begin
        if (exp_q.size() > 0) chk("rd_data", sd_buff_dout, exp_q.pop_front());
        else                  chk("rd_extra", exp_q.size(), 1);
      end
      @(negedge clk_sys);
      c++;
    end
    if (aborted) begin
      exp_q.delete();
      return;
    end
    chk("ack_len", c, 1024);
    chk("sb_left", exp_q.size(), 0);
    chk("gap_busy", busy, 1);
    chk("err", err, (!in_rng || (wr && !rd && wp)));
    if (wr && !rd && in_rng && !wp)
      for (int k = 0; k < 512; k++) model[int'(lba[5:0]) * 512 + k] = pat(sel, lba, 9'(k));
    @(negedge clk_sys);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    chk("rst_ack", sd_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_bwr", sd_buff_wr, 0);
    chk("rst_addr", {23'd0, sd_buff_addr}, 0);
    chk("rst_dout", {24'd0, sd_buff_dout}, 0);
    RESET_n = 1'b1;
    @(negedge clk_sys);

    for (int i = 0; i < 512; i++) pb_write(3 * 512 + i, 8'(i));
    for (int i = 0; i < 512; i++) pb_write(0 * 512 + i, 8'(i * 7 + 1));
    for (int i = 0; i < 512; i++) pb_write(4 * 512 + i, 8'(i + 8'h33));
    for (int i = 0; i < 512; i++) pb_write(6 * 512 + i, 8'(i ^ 8'hC3));

    do_xfer(32'd3, 1'b1, 1'b0, 0, -1);
    do_xfer(32'd5, 1'b0, 1'b1, 0, -1);
    for (int i = 0; i < 512; i++) pb_chk(5 * 512 + i);
    for (int i = 0; i < 512; i += 37) begin
      pb_chk(4 * 512 + i);
      pb_chk(6 * 512 + i);
    end
    pb_chk(4 * 512 + 511);
    pb_chk(6 * 512);

    do_xfer(32'd64, 1'b1, 1'b0, 0, -1);
    do_xfer(32'd0, 1'b1, 1'b0, 0, -1);
    do_xfer(32'd3, 1'b1, 1'b1, 0, -1);
    for (int i = 0; i < 512; i += 64) pb_chk(3 * 512 + i);

    for (int l = 0; l < SECTORS; l++) do_xfer(32'(l), 1'b0, 1'b1, 1, -1);
    for (int l = 0; l < SECTORS; l++) begin
      pb_chk(l * 512);
      pb_chk(l * 512 + 511);
      pb_chk(l * 512 + int'($urandom_range(1, 510)));
    end

    do_xfer(32'd7, 1'b0, 1'b1, 2, 100);
    @(negedge clk_sys);
    RESET_n = 1'b1;
    @(negedge clk_sys);
    chk("post_rst_busy", busy, 0);
    pb_chk(7 * 512);
    pb_chk(7 * 512 + 99);
    pb_chk(7 * 512 + 100);
    pb_chk(7 * 512 + 511);
    do_xfer(32'd7, 1'b1, 1'b0, 0, -1);

`ifdef SD_WRPROT_EN
    wp = 1'b1;
    do_xfer(32'd2, 1'b0, 1'b1, 0, -1);
    wp = 1'b0;
    for (int i = 0; i < 512; i += 51) pb_chk(2 * 512 + i);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
